// File: rtl/fibergyro_frame_ctrl.sv
// Command/response frame engine between the system bus and a CoreUART on the fibre-gyro RS422 link.
// Reply checksum checking is built only when FIBGY_CKSUM_EN is defined.
module fibergyro_frame_ctrl #(
  parameter int unsigned CMD_LEN     = 4,
  parameter int unsigned FRAME_LEN   = 16,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 65000,
  parameter logic [12:0] BAUD_DEF    = 13'd325
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic        baud_we,
  input  logic [12:0] baud_wdata,
  input  logic        start,
  input  logic [4:0]  rsp_addr,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        done,
  output logic        err_hdr,
  output logic        err_tmo,
  output logic        err_cks,
  input  logic        TXrd,
  input  logic        RXrd,
  input  logic [7:0]  RX,
  output logic [7:0]  TX,
  output logic        WEN,
  output logic        OEN,
  output logic [12:0] BAUD_val,
  output logic        FIBERGYRO_TX_EN,
  output logic        FIBERGYRO_RX_EN
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned TMR_W = 16;
  localparam logic [IDX_W-1:0] CMD_LAST = IDX_W'(CMD_LEN - 1);
  localparam logic [IDX_W-1:0] FRM_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, TX_PUT, TX_GUARD, RX_WAIT, RX_GET, RX_GUARD, CHECK, FIN
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TMR_W-1:0]   timer_q;
  logic               gcnt_q;
  logic               flush_gd_q;
  logic [7:0]         tx_q;
  logic               wen_q;
  logic               oen_q;
  logic [12:0]        baud_q;
  logic               busy_q;
  logic               done_q;
  logic               err_hdr_q;
  logic               err_tmo_q;
  logic [7:0]         cmd_q [16];
  logic [7:0]         rsp_q [32];

  // Main sequencer; strobes default inactive and are pulled low for single cycles.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      gcnt_q     <= 1'b0;
      flush_gd_q <= 1'b0;
      tx_q       <= 8'h00;
      wen_q      <= 1'b1;
      oen_q      <= 1'b1;
      baud_q     <= BAUD_DEF;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_hdr_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wen_q  <= 1'b1;
      oen_q  <= 1'b1;
      tx_q   <= 8'h00;
      if (baud_we && !busy_q) baud_q <= baud_wdata;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= TX_PUT;
            busy_q     <= 1'b1;
            idx_q      <= '0;
            err_hdr_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            flush_gd_q <= 1'b0;
          end else if (!oen_q) begin
            flush_gd_q <= 1'b1;
          end else if (flush_gd_q) begin
            flush_gd_q <= 1'b0;
          end else if (RXrd) begin
            oen_q <= 1'b0;
          end
        end
        TX_PUT: begin
          if (TXrd) begin
            tx_q    <= cmd_q[idx_q[3:0]];
            wen_q   <= 1'b0;
            gcnt_q  <= 1'b0;
            state_q <= TX_GUARD;
          end
        end
        TX_GUARD: begin
          if (!gcnt_q) begin
            gcnt_q <= 1'b1;
          end else if (idx_q == CMD_LAST) begin
            idx_q   <= '0;
            timer_q <= '0;
            state_q <= RX_WAIT;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= TX_PUT;
          end
        end
        RX_WAIT: begin
          // A byte arriving on the terminal cycle still wins over the timeout.
          if (RXrd) begin
            oen_q   <= 1'b0;
            state_q <= RX_GET;
          end else if (timer_q == TMO_LAST) begin
            err_tmo_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= FIN;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RX_GET: begin
          timer_q <= '0;
          state_q <= RX_GUARD;
        end
        RX_GUARD: begin
          if (idx_q == FRM_LAST) begin
            state_q <= CHECK;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= RX_WAIT;
          end
        end
        CHECK: begin
          err_hdr_q <= (rsp_q[0] != HDR_BYTE);
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= FIN;
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Command and reply buffers survive reset.
  always_ff @(posedge CLK) begin
    if (cmd_we && !busy_q) cmd_q[cmd_addr] <= cmd_wdata;
    if (state_q == RX_GET) rsp_q[idx_q] <= RX;
  end

`ifdef FIBGY_CKSUM_EN
  logic [7:0] sum_q;
  logic       err_cks_q;

  // Running sum of payload bytes 1..FRAME_LEN-2, compared against the trailing byte.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sum_q     <= 8'h00;
      err_cks_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      sum_q     <= 8'h00;
      err_cks_q <= 1'b0;
    end else if (state_q == RX_GET && idx_q != '0 && idx_q != FRM_LAST) begin
      sum_q <= sum_q + RX;
    end else if (state_q == CHECK) begin
      err_cks_q <= (sum_q != rsp_q[FRM_LAST]);
    end
  end

  assign err_cks = err_cks_q;
`else
  assign err_cks = 1'b0;
`endif

  assign rsp_data        = ({1'b0, rsp_addr} < 6'(FRAME_LEN)) ? rsp_q[rsp_addr] : 8'h00;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_hdr         = err_hdr_q;
  assign err_tmo         = err_tmo_q;
  assign TX              = tx_q;
  assign WEN             = wen_q;
  assign OEN             = oen_q;
  assign BAUD_val        = baud_q;
  assign FIBERGYRO_TX_EN = !wen_q;
  assign FIBERGYRO_RX_EN = oen_q;

endmodule

// File: tb/tb_fibergyro_frame_ctrl.sv
// Randomized bench for fibergyro_frame_ctrl with a CoreUART stand-in and a frame-level reference model.
module tb_fibergyro_frame_ctrl;

  localparam int unsigned CMD_LEN   = 4;
  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned TMO       = 100;
  localparam logic [7:0]  HDR       = 8'hA5;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        baud_we = 1'b0;
  logic [12:0] baud_wdata = '0;
  logic        start = 1'b0;
  logic [4:0]  rsp_addr = '0;
  logic [7:0]  rsp_data;
  logic        busy, done, err_hdr, err_tmo, err_cks;
  logic        TXrd = 1'b1;
  logic        RXrd = 1'b0;
  logic [7:0]  RX = '0;
  logic [7:0]  TX;
  logic        WEN, OEN;
  logic [12:0] BAUD_val;
  logic        FIBERGYRO_TX_EN, FIBERGYRO_RX_EN;

  fibergyro_frame_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .baud_we(baud_we), .baud_wdata(baud_wdata),
    .start(start), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .busy(busy), .done(done), .err_hdr(err_hdr), .err_tmo(err_tmo), .err_cks(err_cks),
    .TXrd(TXrd), .RXrd(RXrd), .RX(RX), .TX(TX), .WEN(WEN), .OEN(OEN),
    .BAUD_val(BAUD_val), .FIBERGYRO_TX_EN(FIBERGYRO_TX_EN), .FIBERGYRO_RX_EN(FIBERGYRO_RX_EN)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0, done_cnt = 0, done_cyc = 0, oen_cnt = 0, last_oen_cyc = 0, gap = 0;
  bit prev_wen_low = 1'b0;
  bit tx_rand = 1'b0;
  byte unsigned tx_log[$];
  int           wen_cyc[$];
  byte unsigned rxq[$];
  byte unsigned rep[$];
  logic [7:0]   cmd_m [16];
  logic [7:0]   rsp_m [FRAME_LEN];
  bit           rsp_v [FRAME_LEN];
  logic [12:0]  baud_m = 13'd325;
  logic         p_hdr = 1'b0, p_tmo = 1'b0, p_cks = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // CoreUART stand-in: logs write strobes, serves queued reply bytes, randomizes TXRDY.
  task automatic monitor();
    cyc++;
    if (RESET) begin
      if (!WEN) begin
        check_eq("wen_width", 32'(prev_wen_low), 32'd0);
        check_eq("tx_en", 32'(FIBERGYRO_TX_EN), 32'd1);
        tx_log.push_back(TX);
        wen_cyc.push_back(cyc);
      end
      prev_wen_low = !WEN;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!OEN) begin
        check_eq("oen_with_rxrd", 32'(RXrd), 32'd1);
        check_eq("rx_en", 32'(FIBERGYRO_RX_EN), 32'd0);
        oen_cnt++;
        last_oen_cyc = cyc;
        if (RXrd && rxq.size() > 0) void'(rxq.pop_front());
        RXrd = 1'b0;
        gap = $urandom_range(0, 3);
      end else if (!RXrd && rxq.size() > 0) begin
        if (gap > 0) gap--;
        else begin
          RX   = rxq[0];
          RXrd = 1'b1;
        end
      end
      TXrd = tx_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end else begin
      prev_wen_low = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_rsp();
    for (int i = 0; i < 32; i++) begin
      rsp_addr = 5'(i);
      step();
      if (i >= int'(FRAME_LEN)) check_eq("rsp_oob", 32'(rsp_data), 32'd0);
      else if (rsp_v[i]) check_eq($sformatf("rsp[%0d]", i), 32'(rsp_data), 32'(rsp_m[i]));
    end
  endtask

  // One full transaction replying with the bytes in rep; expectations from frame-level rules.
  task automatic run_txn(input bit rnd_cmd, input bit timing);
    int n, d0, o0, sc;
    logic e_hdr, e_tmo, e_cks;
    logic [7:0] s;
    n = rep.size();
    if (rnd_cmd) for (int i = 0; i < int'(CMD_LEN); i++) cmd_m[i] = 8'($urandom);
    for (int i = 0; i < int'(CMD_LEN); i++) begin
      cmd_we = 1'b1; cmd_addr = 4'(i); cmd_wdata = cmd_m[i];
      step();
    end
    cmd_we = 1'b0;
    check_eq("err_hdr_held", 32'(err_hdr), 32'(p_hdr));
    check_eq("err_tmo_held", 32'(err_tmo), 32'(p_tmo));
    check_eq("err_cks_held", 32'(err_cks), 32'(p_cks));

    tx_log.delete(); wen_cyc.delete();
    d0 = done_cnt; o0 = oen_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    sc = cyc;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("errs_cleared", 32'({err_hdr, err_tmo, err_cks}), 32'd0);
    foreach (rep[i]) rxq.push_back(rep[i]);
    step(); step();
    // start, command and baud writes while busy have no effect
    start = 1'b1; cmd_we = 1'b1; cmd_addr = 4'(CMD_LEN - 1); cmd_wdata = ~cmd_m[CMD_LEN-1];
    baud_we = 1'b1; baud_wdata = ~baud_m;
    step();
    start = 1'b0; cmd_we = 1'b0; baud_we = 1'b0;

    for (int k = 0; k < 4000 && done_cnt == d0; k++) step();
    check_eq("done_seen", 32'(done_cnt != d0), 32'd1);

    if (n < int'(FRAME_LEN)) begin
      e_tmo = 1'b1; e_hdr = 1'b0; e_cks = 1'b0;
    end else begin
      e_tmo = 1'b0;
      e_hdr = (rep[0] != HDR);
      s = 8'h00;
      for (int i = 1; i <= int'(FRAME_LEN) - 2; i++) s = s + rep[i];
`ifdef FIBGY_CKSUM_EN
      e_cks = (s != rep[FRAME_LEN-1]);
`else
      e_cks = 1'b0;
`endif
    end
    check_eq("done_width", 32'(done), 32'd0);
    check_eq("busy_at_end", 32'(busy), 32'd0);
    check_eq("err_hdr", 32'(err_hdr), 32'(e_hdr));
    check_eq("err_tmo", 32'(err_tmo), 32'(e_tmo));
    check_eq("err_cks", 32'(err_cks), 32'(e_cks));
    check_eq("baud_kept", 32'(BAUD_val), 32'(baud_m));
    // after the last byte read: one guard cycle, TMO empty wait cycles, then the done cycle
    if (e_tmo && n > 0) check_eq("tmo_latency", 32'(done_cyc - last_oen_cyc), 32'(TMO + 2));

    for (int k = 0; k < 200 && rxq.size() > 0; k++) step();
    repeat (4) step();
    check_eq("bytes_consumed", 32'(oen_cnt - o0), 32'(n));
    check_eq("done_count", 32'(done_cnt - d0), 32'd1);
    check_eq("tx_count", 32'(tx_log.size()), 32'(CMD_LEN));
    for (int i = 0; i < int'(CMD_LEN) && i < tx_log.size(); i++)
      check_eq($sformatf("tx_byte[%0d]", i), 32'(tx_log[i]), 32'(cmd_m[i]));
    if (timing && wen_cyc.size() == int'(CMD_LEN)) begin
      check_eq("first_wen_latency", 32'(wen_cyc[0] - sc), 32'd2);
      for (int i = 1; i < int'(CMD_LEN); i++)
        check_eq("wen_spacing", 32'(wen_cyc[i] - wen_cyc[i-1]), 32'd3);
    end

    for (int i = 0; i < n && i < int'(FRAME_LEN); i++) begin
      rsp_m[i] = rep[i];
      rsp_v[i] = 1'b1;
    end
    check_rsp();
    p_hdr = e_hdr; p_tmo = e_tmo; p_cks = e_cks;
  endtask

  task automatic build_rep(input int n, input bit good_hdr, input bit good_cks);
    logic [7:0] s;
    rep.delete();
    for (int i = 0; i < n; i++) rep.push_back(8'($urandom));
    if (n > 0) rep[0] = good_hdr ? HDR : (HDR ^ 8'(1 + $urandom_range(0, 254)));
    if (n >= int'(FRAME_LEN)) begin
      s = 8'h00;
      for (int i = 1; i <= int'(FRAME_LEN) - 2; i++) s = s + rep[i];
      rep[FRAME_LEN-1] = good_cks ? s : s + 8'(1 + $urandom_range(0, 254));
    end
  endtask

  initial begin
    int d0, o0, r, n;
    for (int i = 0; i < int'(FRAME_LEN); i++) rsp_v[i] = 1'b0;

    // reset values
    repeat (3) step();
    check_eq("rst_baud", 32'(BAUD_val), 32'd325);
    check_eq("rst_wen", 32'(WEN), 32'd1);
    check_eq("rst_oen", 32'(OEN), 32'd1);
    check_eq("rst_tx", 32'(TX), 32'd0);
    check_eq("rst_busy_done", 32'({busy, done}), 32'd0);
    check_eq("rst_errs", 32'({err_hdr, err_tmo, err_cks}), 32'd0);
    check_eq("rst_enables", 32'({FIBERGYRO_TX_EN, FIBERGYRO_RX_EN}), 32'b01);
    RESET = 1'b1;
    repeat (2) step();

    baud_we = 1'b1; baud_wdata = 13'd162;
    step();
    baud_we = 1'b0;
    check_eq("baud_load", 32'(BAUD_val), 32'd162);
    baud_m = 13'd162;

    // directed: fixed command, good frame with sum 0x5B
    for (int i = 0; i < int'(CMD_LEN); i++) cmd_m[i] = 8'(i + 1);
    rep.delete();
    rep.push_back(HDR);
    for (int i = 0; i < 14; i++) rep.push_back(8'(i));
    rep.push_back(8'h5B);
    run_txn(1'b0, 1'b1);

    rep[FRAME_LEN-1] = 8'h5C;
    run_txn(1'b0, 1'b1);
    rep[FRAME_LEN-1] = 8'h5B;
    rep[0] = 8'h5A;
    run_txn(1'b0, 1'b1);

    build_rep(7, 1'b1, 1'b1);
    run_txn(1'b1, 1'b1);
    build_rep(18, 1'b1, 1'b1);
    run_txn(1'b1, 1'b1);

    tx_rand = 1'b1;
    for (int t = 0; t < 16; t++) begin
      r = $urandom_range(0, 9);
      n = (r < 6) ? int'(FRAME_LEN) : (r < 8) ? $urandom_range(1, 15) : $urandom_range(17, 19);
      build_rep(n, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      run_txn(1'b1, 1'b0);
    end
    tx_rand = 1'b0;

    // stale byte while idle is read once and discarded
    o0 = oen_cnt;
    rxq.push_back(8'h3C);
    repeat (10) step();
    check_eq("stale_oen_pulses", 32'(oen_cnt - o0), 32'd1);
    check_eq("stale_drained", 32'(rxq.size()), 32'd0);
    check_eq("stale_idle", 32'(busy), 32'd0);
    check_rsp();

    // reset in the middle of the reply wait
    for (int i = 0; i < int'(CMD_LEN); i++) begin
      cmd_we = 1'b1; cmd_addr = 4'(i); cmd_wdata = cmd_m[i];
      step();
    end
    cmd_we = 1'b0;
    tx_log.delete();
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 100 && tx_log.size() < int'(CMD_LEN); k++) step();
    repeat (5) step();
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2 RESET = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_oen", 32'(OEN), 32'd1);
    check_eq("mid_rst_baud", 32'(BAUD_val), 32'd325);
    repeat (2) step();
    RESET = 1'b1;
    baud_m = 13'd325;
    repeat (TMO + 20) step();
    check_eq("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    check_eq("idle_after_rst", 32'({busy, err_tmo}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
